j_dac_sched: RTL

J_DAC_SCHED -- requirements
Module: j_dac_sched

---
 rtl/j_dac_sched_if.sv | 31 +++
 rtl/j_dac_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/j_dac_sched_if.sv
// Bus bundle for the stereo DAC scheduler: sample push/tick controls in, DAC strobes and status out.
// dbg_state mirrors the sequencing FSM so checkers can bind to it without reaching into the block.
interface j_dac_sched_if;
  logic        en;
  logic        tint;
  logic        push;
  logic [15:0] wl;
  logic [15:0] wr;
  logic [2:0]  thresh;
  logic        clr;
  logic        dac1w;
  logic        dac2w;
  logic [15:0] dspd;
  logic [2:0]  level;
  logic        full;
  logic        irq;
  logic        ur;
  logic        ovf;
  logic        late;
  logic [1:0]  dbg_state;

  modport master (
    output en, tint, push, wl, wr, thresh, clr,
    input  dac1w, dac2w, dspd, level, full, irq, ur, ovf, late, dbg_state
  );

  modport slave (
    input  en, tint, push, wl, wr, thresh, clr,
    output dac1w, dac2w, dspd, level, full, irq, ur, ovf, late, dbg_state
  );
endinterface

// File: rtl/j_dac_sched.sv
// Stereo DAC scheduler: 4-entry {left,right} FIFO drained one pair per sample tick,
// writing left then right on consecutive cycles, with low-water irq and sticky error flags.
module j_dac_sched (
  input  logic          clk,
  input  logic          resetl,
  j_dac_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  level_q, level_d;
  logic        full_q, full_d;
  logic [15:0] hl_q, hl_d;
  logic [15:0] hr_q, hr_d;
  logic [15:0] dspd_q, dspd_d;
  logic        dac1w_q, dac1w_d;
  logic        dac2w_q, dac2w_d;
  logic        irq_q, irq_d;
  logic        ur_q, ur_d;
  logic        ovf_q, ovf_d;
  logic        late_q, late_d;

  logic        pop;
  logic        wr_en;
  logic        ur_set;
  logic        ovf_set;
  logic        late_set;
  logic        at_full;
  logic [31:0] head;
  logic [2:0]  thr_eff;

  // Sequencer: a tick in IDLE starts a left/right pair; ticks mid-pair are flagged late.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    ur_set   = 1'b0;
    late_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en && bus.tint) begin
          state_d = S_LEFT;
          if (level_q != 3'd0) pop = 1'b1;
          else                 ur_set = 1'b1;
        end
      end
      S_LEFT: begin
        state_d  = S_RIGHT;
        late_set = bus.en && bus.tint;
      end
      S_RIGHT: begin
        state_d  = S_IDLE;
        late_set = bus.en && bus.tint;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a simultaneous pop frees the slot a full-FIFO push needs.
  always_comb begin
    at_full = (level_q == 3'd4);
    wr_en   = bus.push && (!at_full || pop);
    ovf_set = bus.push && at_full && !pop;
    wptr_d  = wr_en ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = pop   ? rptr_q + 2'd1 : rptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == 3'd4);
    head    = mem_q[rptr_q];
    hl_d    = pop ? head[31:16] : hl_q;
    hr_d    = pop ? head[15:0]  : hr_q;
    thr_eff = (bus.thresh > 3'd4) ? 3'd4 : bus.thresh;
    irq_d   = (level_d <= thr_eff) && bus.en;
  end

  // Strobes and data are computed from the next state so they are registered, not decoded.
  always_comb begin
    dac1w_d = (state_d == S_LEFT);
    dac2w_d = (state_d == S_RIGHT);
    dspd_d  = dspd_q;
    if (state_d == S_LEFT)       dspd_d = hl_d;
    else if (state_d == S_RIGHT) dspd_d = hr_q;
    ur_d   = ur_set   || (ur_q   && !bus.clr);
    ovf_d  = ovf_set  || (ovf_q  && !bus.clr);
    late_d = late_set || (late_q && !bus.clr);
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      level_q <= 3'd0;
      full_q  <= 1'b0;
      hl_q    <= 16'd0;
      hr_q    <= 16'd0;
      dspd_q  <= 16'd0;
      dac1w_q <= 1'b0;
      dac2w_q <= 1'b0;
      irq_q   <= 1'b0;
      ur_q    <= 1'b0;
      ovf_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      hl_q    <= hl_d;
      hr_q    <= hr_d;
      dspd_q  <= dspd_d;
      dac1w_q <= dac1w_d;
      dac2w_q <= dac2w_d;
      irq_q   <= irq_d;
      ur_q    <= ur_d;
      ovf_q   <= ovf_d;
      late_q  <= late_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {bus.wl, bus.wr};
  end

  assign bus.dac1w     = dac1w_q;
  assign bus.dac2w     = dac2w_q;
  assign bus.dspd      = dspd_q;
  assign bus.level     = level_q;
  assign bus.full      = full_q;
  assign bus.irq       = irq_q;
  assign bus.ur        = ur_q;
  assign bus.ovf       = ovf_q;
  assign bus.late      = late_q;
  assign bus.dbg_state = state_q;

endmodule
